arm_instr_encoder_writer: RTL and testbench
===========================================

Name: arm_instr_encoder_writer

Overview:
Inverse of the team's ARM control-unit decoder. It accepts decoded instruction fields over a valid/ready handshake and encodes them into a 32-bit ARM instruction word. It then writes that word big-endian, one byte per cycle, into the byte-addressed instruction memory at an auto-incrementing pointer. Bench and bring-up logic use it to load programs that the existing decoder must round-trip exactly.

Parameters:
ADDR_W, 8, instruction-memory byte-address width; capacity = 2^ADDR_W/4 words.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle
in_class  input  2  00 data-proc, 01 load/store, 10 branch, 11 NOP
cond  input  4  condition field, bits[31:28]
dp_op  input  4  data-proc opcode, bits[24:21]
s_bit  input  1  data-proc S flag, bit 20
rn  input  4  base/first-operand register
rd  input  4  destination/source register
imm12  input  12  immediate operand / offset
ls_load  input  1  1 = load, 0 = store
ls_byte  input  1  1 = byte, 0 = word
ls_up  input  1  U bit
br_link  input  1  1 = BL, 0 = B
br_offset  input  24  branch offset, bits[23:0]
ptr_clr  input  1  sync clear of pointer, count and full; honoured in IDLE only
mem_we  output  1  byte write strobe
mem_addr  output  ADDR_W  byte address
mem_data  output  8  byte data
instr_word  output  32  last encoded word, held until next accept
done  output  1  1-cycle pulse after the 4th byte
err  output  1  1-cycle pulse on rejected bundle
full  output  1  memory filled
instr_count  output  ADDR_W-1  words written since clear

Behaviour:
- Reset (async, immediate): state IDLE; mem_we, done, err, full = 0; mem_addr, mem_data, instr_word, instr_count, internal pointer = 0; in_ready = 1.
- in_ready = (state == IDLE) && !full. A bundle is accepted on a clk edge where in_valid && in_ready.
- Encoding:
  - Data-proc: {cond, 3'b001, dp_op, s_bit, rn, rd, imm12}.
  - Load/store: {cond, 3'b010, 1'b1, ls_up, ~ls_byte, 1'b0, ls_load, rn, rd, imm12}. Bit 22 = 1 means word; this matches the control unit.
  - Branch: {cond, 3'b101, ~br_link, br_offset}. Bit 24 = 1 means B; this matches the control unit.
  - NOP: 32'h00000000, cond ignored.
- Rejection: data-proc with dp_op in 4'b1000..4'b1011 is illegal.
  - err pulses the cycle after accept.
  - No memory write; pointer, count and instr_word unchanged; state stays IDLE.
- FSM IDLE -> WRITE -> IDLE:
  - Accept at edge N registers instr_word and enters WRITE with byte index 0.
  - WRITE holds for 4 cycles, N+1..N+4: mem_we = 1, mem_addr = ptr + idx, mem_data = instr_word[31-8*idx -: 8] (MSB byte first).
  - Edge N+4: ptr += 4 (mod 2^ADDR_W), instr_count += 1, state returns to IDLE.
  - Cycle N+5: done = 1, mem_we = 0.
  - Back-to-back: next accept is possible at edge N+5, so one instruction takes 5 cycles.
- in_valid and fields are sampled only at accept; changes during WRITE are ignored.
- Full:
  - When the word at byte address 2^ADDR_W-4 completes, ptr wraps to 0 and full = 1.
  - full stays 1 until ptr_clr or reset; no further accepts while full.
- ptr_clr in IDLE (takes priority over a simultaneous accept, which is not taken): next edge sets ptr = 0, instr_count = 0, full = 0. ptr_clr during WRITE is ignored.
- Reset asserted mid-WRITE aborts immediately: the partial word stays in memory, and the pointer is lost (0).

Test Plan:
- Data-proc ADD R1,R2,#5 AL (class 00, cond E, op 0100, s 0, rn 2, rd 1, imm 005) accepted at N -> instr_word 0xE2821005; bytes E2,82,10,05 at addr 0..3 in N+1..N+4; done at N+5; instr_count 1.
- LDR R3,[R4,#8] AL (class 01, load 1, byte 0, up 1, rn 4, rd 3, imm 008), after test 1 -> 0xE5D43008 written at addr 4..7; STRB same fields -> 0xE5843008.
- B offset 0x000010 AL -> 0xEB000010; BL same offset -> 0xEA000010; NOP with cond 0 -> 0x00000000, four zero bytes written.
- Data-proc dp_op 1010 -> err pulse, no mem_we, pointer and instr_word unchanged, in_ready stays 1.
- ADDR_W=4, four valid bundles back-to-back -> writes at 0,4,8,12; full=1 and in_ready=0 after the 4th; ptr_clr -> full=0, instr_count=0, next write at addr 0.
- reset_n low after 2 bytes of a word -> mem_we drops in the same cycle; all outputs 0; after release, in_ready=1 and the next write lands at addr 0.

Source files
------------

// File: rtl/arm_instr_encoder_writer.sv
// arm_instr_encoder_writer
//   Encodes a decoded ARM instruction field bundle into a 32-bit word and writes it big-endian,
//   one byte per cycle, into a byte-addressed instruction memory at an auto-incrementing
//   pointer. One legal instruction takes 5 cycles (accept + 4 byte writes); back-to-back
//   accepts are possible on the cycle after the 4th byte.
//
// Ports
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_in_valid/o_in_ready   field bundle handshake; ready = idle and memory not full
//   i_in_class              00 data-proc, 01 load/store, 10 branch, 11 NOP
//   i_cond .. i_br_offset   decoded instruction fields
//   i_ptr_clr               clears pointer, word count and full flag (idle only)
//   o_mem_we/addr/data      byte write port to instruction memory
//   o_instr_word            last encoded (accepted, legal) word
//   o_done                  1-cycle pulse after the 4th byte of a word
//   o_err                   1-cycle pulse after an illegal bundle is accepted
//   o_full                  memory filled; set when the pointer wraps to 0
//   o_instr_count           words written since the last clear
module arm_instr_encoder_writer #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [1:0]        i_in_class,
    input  logic [3:0]        i_cond,
    input  logic [3:0]        i_dp_op,
    input  logic              i_s_bit,
    input  logic [3:0]        i_rn,
    input  logic [3:0]        i_rd,
    input  logic [11:0]       i_imm12,
    input  logic              i_ls_load,
    input  logic              i_ls_byte,
    input  logic              i_ls_up,
    input  logic              i_br_link,
    input  logic [23:0]       i_br_offset,
    input  logic              i_ptr_clr,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic [31:0]       o_instr_word,
    output logic              o_done,
    output logic              o_err,
    output logic              o_full,
    output logic [ADDR_W-2:0] o_instr_count
);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [1:0]        r_idx;
    logic [31:0]       r_word;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_data;
    logic              r_done;
    logic              r_err;
    logic              r_full;
    logic [ADDR_W-2:0] r_count;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_accept;
    logic [1:0]        w_idx_next;
    logic [7:0]        w_byte_next;
    logic [ADDR_W-1:0] w_ptr_next;

    always_comb begin
        w_word = 32'h0000_0000;
        case (i_in_class)
            2'b00:   w_word = {i_cond, 3'b001, i_dp_op, i_s_bit, i_rn, i_rd, i_imm12};
            // Bit 22 set selects a word transfer, so it is the inverse of ls_byte.
            2'b01:   w_word = {i_cond, 3'b010, 1'b1, i_ls_up, ~i_ls_byte, 1'b0, i_ls_load,
                               i_rn, i_rd, i_imm12};
            // Bit 24 set means plain B, so it is the inverse of br_link.
            2'b10:   w_word = {i_cond, 3'b101, ~i_br_link, i_br_offset};
            default: w_word = 32'h0000_0000;
        endcase
    end

    // Opcodes 1000..1011 (TST/TEQ/CMP/CMN slots) are not produced by the decoder.
    assign w_illegal  = (i_in_class == 2'b00) && (i_dp_op[3:2] == 2'b10);
    assign o_in_ready = (r_state == StIdle) && !r_full;
    // A simultaneous pointer clear wins over the bundle.
    assign w_accept   = i_in_valid && o_in_ready && !i_ptr_clr;

    assign w_idx_next = r_idx + 2'd1;
    assign w_ptr_next = r_ptr + ADDR_W'(4);

    always_comb begin
        w_byte_next = r_word[31:24];
        case (w_idx_next)
            2'd0:    w_byte_next = r_word[31:24];
            2'd1:    w_byte_next = r_word[23:16];
            2'd2:    w_byte_next = r_word[15:8];
            default: w_byte_next = r_word[7:0];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_idx      <= 2'd0;
            r_word     <= 32'h0000_0000;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= 8'h00;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_full     <= 1'b0;
            r_count    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_ptr_clr) begin
                        r_ptr   <= '0;
                        r_count <= '0;
                        r_full  <= 1'b0;
                    end else if (w_accept) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            // First byte is presented in the cycle right after accept.
                            r_word     <= w_word;
                            r_idx      <= 2'd0;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= r_ptr;
                            r_mem_data <= w_word[31:24];
                            r_state    <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (r_idx == 2'd3) begin
                        r_mem_we <= 1'b0;
                        r_ptr    <= w_ptr_next;
                        r_count  <= r_count + (ADDR_W-1)'(1);
                        r_done   <= 1'b1;
                        r_state  <= StIdle;
                        // Wrap to 0 means the last word slot has just been written.
                        if (w_ptr_next == '0) begin
                            r_full <= 1'b1;
                        end
                    end else begin
                        r_idx      <= w_idx_next;
                        r_mem_addr <= r_ptr + {{(ADDR_W-2){1'b0}}, w_idx_next};
                        r_mem_data <= w_byte_next;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data    = r_mem_data;
    assign o_instr_word  = r_word;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_full        = r_full;
    assign o_instr_count = r_count;

endmodule

// File: tb/tb_arm_instr_encoder_writer.sv
// Scoreboard bench: the driver pushes expected memory writes / done / err events, a monitor
// on the falling edge pops and compares whenever the DUT presents one.
module tb_arm_instr_encoder_writer;

    localparam int unsigned AW  = 4;
    localparam int          CAP = 16; // bytes

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_class = '0;
    logic [3:0]    cond = '0;
    logic [3:0]    dp_op = '0;
    logic          s_bit = 1'b0;
    logic [3:0]    rn = '0;
    logic [3:0]    rd = '0;
    logic [11:0]   imm12 = '0;
    logic          ls_load = 1'b0;
    logic          ls_byte = 1'b0;
    logic          ls_up = 1'b0;
    logic          br_link = 1'b0;
    logic [23:0]   br_offset = '0;
    logic          ptr_clr = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [31:0]   instr_word;
    logic          done;
    logic          err;
    logic          full;
    logic [AW-2:0] instr_count;

    arm_instr_encoder_writer #(.ADDR_W(AW)) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_class    (in_class),
        .i_cond        (cond),
        .i_dp_op       (dp_op),
        .i_s_bit       (s_bit),
        .i_rn          (rn),
        .i_rd          (rd),
        .i_imm12       (imm12),
        .i_ls_load     (ls_load),
        .i_ls_byte     (ls_byte),
        .i_ls_up       (ls_up),
        .i_br_link     (br_link),
        .i_br_offset   (br_offset),
        .i_ptr_clr     (ptr_clr),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_data    (mem_data),
        .o_instr_word  (instr_word),
        .o_done        (done),
        .o_err         (err),
        .o_full        (full),
        .o_instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cls;
        logic [3:0]  cond;
        logic [3:0]  op;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] imm;
        logic        load;
        logic        byt;
        logic        up;
        logic        link;
        logic [23:0] off;
    } bundle_t;

    // kind: 0 byte write, 1 done, 2 err
    typedef struct {
        int          kind;
        int          cyc;
        int          addr;
        int          data;
        logic [31:0] word;
        int          count;
        int          full;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    int          m_count = 0;
    int          m_full = 0;
    logic [31:0] m_word = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoding built arithmetically from the field definitions.
    function automatic logic [31:0] encode(input bundle_t b);
        case (b.cls)
            2'd0: return (32'(b.cond) << 28) + (32'd1 << 25) + (32'(b.op) << 21)
                       + (32'(b.s) << 20) + (32'(b.rn) << 16) + (32'(b.rd) << 12) + 32'(b.imm);
            2'd1: return (32'(b.cond) << 28) + (32'd2 << 25) + (32'd1 << 24) + (32'(b.up) << 23)
                       + (32'(!b.byt) << 22) + (32'(b.load) << 20) + (32'(b.rn) << 16)
                       + (32'(b.rd) << 12) + 32'(b.imm);
            2'd2: return (32'(b.cond) << 28) + (32'd5 << 25) + (32'(!b.link) << 24) + 32'(b.off);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit illegal(input bundle_t b);
        return (b.cls == 2'd0) && (b.op >= 4'd8) && (b.op <= 4'd11);
    endfunction

    function automatic bundle_t rand_bundle();
        logic [63:0] r;
        bundle_t     b;
        r = {$urandom, $urandom};
        b = r[58:0];
        return b;
    endfunction

    function automatic bundle_t mk(input int cls, input int cnd, input int op, input int rn_v,
                                   input int rd_v, input int imm, input int load, input int byt,
                                   input int up, input int link, input int off);
        bundle_t b;
        b      = '0;
        b.cls  = 2'(cls);
        b.cond = 4'(cnd);
        b.op   = 4'(op);
        b.rn   = 4'(rn_v);
        b.rd   = 4'(rd_v);
        b.imm  = 12'(imm);
        b.load = 1'(load);
        b.byt  = 1'(byt);
        b.up   = 1'(up);
        b.link = 1'(link);
        b.off  = 24'(off);
        return b;
    endfunction

    task automatic apply(input bundle_t b);
        in_class  = b.cls;
        cond      = b.cond;
        dp_op     = b.op;
        s_bit     = b.s;
        rn        = b.rn;
        rd        = b.rd;
        imm12     = b.imm;
        ls_load   = b.load;
        ls_byte   = b.byt;
        ls_up     = b.up;
        br_link   = b.link;
        br_offset = b.off;
    endtask

    task automatic push(input int kind, input int c, input int a, input int d,
                        input logic [31:0] w, input int cnt, input int f);
        exp_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
        e.word = w; e.count = cnt; e.full = f;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_full = 0; m_word = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_data"}, 32'(mem_data), 0);
        check({tag, "_instr_word"}, instr_word, 0);
        check({tag, "_instr_count"}, 32'(instr_count), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
    endtask

    // Offer one bundle. With abort set, reset is pulsed after two bytes of a legal word.
    task automatic send(input bundle_t b, input bit abort);
        int          n;
        logic [31:0] w;
        @(negedge clk);
        apply(b);
        in_valid = 1'b1;
        ptr_clr  = 1'b0;
        check("in_ready", 32'(in_ready), 32'(m_full == 0));
        check("full", 32'(full), 32'(m_full));
        check("instr_count", 32'(instr_count), 32'(m_count));
        check("instr_word", instr_word, m_word);
        if (m_full != 0) begin
            @(posedge clk);
            return;
        end
        n = cyc + 1;
        if (illegal(b)) begin
            push(2, n, 0, 0, 32'h0, 0, 0);
            @(posedge clk);
            return;
        end
        w = encode(b);
        for (int i = 0; i < 4; i++)
            push(0, n + i, (m_ptr + i) % CAP, int'((w >> (24 - 8 * i)) & 32'hFF), 32'h0, 0, 0);
        m_ptr   = (m_ptr + 4) % CAP;
        m_count = m_count + 1;
        if (m_ptr == 0) m_full = 1;
        m_word  = w;
        push(1, n + 4, 0, 0, w, m_count, m_full);
        @(posedge clk);
        if (abort) begin
            @(negedge clk);
            @(negedge clk);
            @(posedge clk);
            #2;
            reset_n = 1'b0;
            q.delete();
            model_reset();
            #1;
            check_reset_outputs("abort");
            @(negedge clk);
            reset_n  = 1'b1;
            in_valid = 1'b0;
            return;
        end
        // Field, valid and clear activity during the write must have no effect.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply(rand_bundle());
            in_valid = 1'($urandom_range(0, 1));
            ptr_clr  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_clr(input bit with_valid);
        @(negedge clk);
        apply(rand_bundle());
        in_valid = with_valid;
        ptr_clr  = 1'b1;
        @(posedge clk);
        m_ptr = 0; m_count = 0; m_full = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            ptr_clr  = 1'b0;
        end
    endtask

    task automatic observe(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        if (kind == 0 && e.kind == 0) begin
            check("mem_addr", 32'(mem_addr), 32'(e.addr));
            check("mem_data", 32'(mem_data), 32'(e.data));
        end
        if (kind == 1 && e.kind == 1) begin
            check("done_word", instr_word, e.word);
            check("done_count", 32'(instr_count), 32'(e.count));
            check("done_full", 32'(full), 32'(e.full));
        end
    endtask

    always @(negedge clk) begin
        if (done) observe(1);
        if (err) observe(2);
        if (mem_we) observe(0);
    end

    initial begin
        bundle_t b;
        int      r;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // ADD R1,R2,#5 / LDR R3,[R4,#8] / STRB / B -> memory full after 4 words
        send(mk(0, 14, 4, 2, 1, 5, 0, 0, 0, 0, 0), 1'b0);
        send(mk(1, 14, 0, 4, 3, 8, 1, 0, 1, 0, 0), 1'b0);
        send(mk(1, 14, 0, 4, 3, 8, 0, 1, 1, 0, 0), 1'b0);
        send(mk(2, 14, 0, 0, 0, 0, 0, 0, 0, 0, 16), 1'b0);
        send(mk(2, 14, 0, 0, 0, 0, 0, 0, 0, 1, 16), 1'b0); // refused while full
        do_clr(1'b1);                                         // clear wins over valid
        send(mk(2, 14, 0, 0, 0, 0, 0, 0, 0, 1, 16), 1'b0);  // BL at addr 0
        send(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);    // NOP at addr 4
        send(mk(0, 14, 10, 2, 1, 5, 0, 0, 0, 0, 0), 1'b0);  // illegal: err only
        send(mk(0, 1, 15, 7, 9, 12'hABC, 0, 0, 0, 0, 0), 1'b0); // lands at addr 8
        send(mk(1, 3, 0, 5, 6, 12'h123, 1, 1, 0, 0, 0), 1'b1);  // reset after 2 bytes
        send(mk(0, 14, 4, 2, 1, 5, 0, 0, 0, 0, 0), 1'b0);   // back at addr 0

        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (m_full != 0 && r < 6) begin
                do_clr(1'($urandom_range(0, 1)));
            end else if (r == 9) begin
                idle(int'($urandom_range(1, 2)));
            end else if (r == 8) begin
                do_clr(1'($urandom_range(0, 1)));
            end else begin
                b = rand_bundle();
                send(b, 1'b0);
            end
        end

        idle(4);
        check("pending_events", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
